// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// UART receiver with a one-frame output register. A frame appears 1 cycle after its last stop sample; the serial line is never stalled.
// A frame that completes while the register is still full is dropped and o_overrun pulses. Optional parity bit: UART_RX_PARITY_EN.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 22274,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_framing_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 ferr;
    logic                 perr;
  } frame_t;

  logic                 rx_meta, rx_sync;
  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 ferr, ferr_n, perr, perr_n;
  logic                 done;
  frame_t               hold;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      ferr    <= 1'b0;
      perr    <= 1'b0;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      ferr    <= ferr_n;
      perr    <= perr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    ferr_n  = ferr;
    perr_n  = perr;
    done    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_sync) state_n = START;
      end
      START: begin
        if (rx_sync) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == HALF) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
          ferr_n  = 1'b0;
          perr_n  = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          // LSB arrives first, so shifting right leaves it in bit 0.
          shift_n = {rx_sync, shift[DATA_BITS-1:1]};
          cnt_n   = '0;
          idx_n   = idx + 1'b1;
          if (idx == LAST_DATA) begin
            idx_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == LAST) begin
          perr_n  = (^shift) ^ rx_sync ^ (PARITY_ODD != 0);
          cnt_n   = '0;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == LAST) begin
          ferr_n = ferr | ~rx_sync;
          cnt_n  = '0;
          if (idx == LAST_STOP) begin
            // Leave mid-stop-bit so the next start edge is never missed.
            state_n = IDLE;
            idx_n   = '0;
            done    = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      hold      <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (done) begin
        if (!o_valid || i_ready) begin
          hold    <= '{data: shift, ferr: ferr_n, perr: perr};
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_data        = hold.data;
  assign o_framing_err = hold.ferr;
  assign o_parity_err  = hold.perr;
  assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_core at 16 clocks per bit, 8 data bits, 1 stop bit.
module tb_uart_rx_core;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int DONE_TICK = 172;
`else
  localparam int DONE_TICK = 156;
`endif

  logic       clk = 1'b0;
  logic       i_reset, i_rx, i_ready;
  logic [7:0] o_data;
  logic       o_valid, o_framing_err, o_parity_err, o_overrun, o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  int         vld_cycles = 0;
  int         hs_cnt     = 0;
  int         ovr_cnt    = 0;
  logic [7:0] hs_data    = 8'h00;
  logic       hs_ferr    = 1'b0;
  logic       hs_perr    = 1'b0;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .i_reset(i_reset), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_framing_err(o_framing_err), .o_parity_err(o_parity_err),
    .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Observe outputs on the falling edge; a handshake is o_valid & i_ready before the next rising edge.
  always @(negedge clk) begin
    if (o_valid) vld_cycles++;
    if (o_valid && i_ready) begin
      hs_cnt++;
      hs_data = o_data;
      hs_ferr = o_framing_err;
      hs_perr = o_parity_err;
    end
    if (o_overrun) ovr_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    vld_cycles = 0;
    hs_cnt     = 0;
    ovr_cnt    = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic stop_v, input logic par_v);
    i_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      repeat (CPB) tick();
    end
`ifdef UART_RX_PARITY_EN
    i_rx = par_v;
    repeat (CPB) tick();
`endif
    i_rx = stop_v;
    repeat (CPB) tick();
    i_rx = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    i_rx    = 1'b1;
    i_ready = 1'b1;
    repeat (3) tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", o_data); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", o_framing_err); end
    n_checks++; if (o_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", o_parity_err); end
    n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", o_overrun); end
    i_reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_basic;
    logic [7:0] pats [4];
    pats = '{8'hA5, 8'h00, 8'hFF, 8'h81};
    i_ready = 1'b1;
    foreach (pats[k]) begin
      clear_mon();
      send(pats[k], 1'b1, ^pats[k]);
      n_checks++; if (vld_cycles !== 1) begin n_fail++; $display("FAIL basic_valid_cycles[%h]: got %0d expected 1", pats[k], vld_cycles); end
      n_checks++; if (hs_data !== pats[k]) begin n_fail++; $display("FAIL basic_data: got %h expected %h", hs_data, pats[k]); end
      n_checks++; if (hs_ferr !== 1'b0) begin n_fail++; $display("FAIL basic_ferr[%h]: got %b expected 0", pats[k], hs_ferr); end
      n_checks++; if (hs_perr !== 1'b0) begin n_fail++; $display("FAIL basic_perr[%h]: got %b expected 0", pats[k], hs_perr); end
      n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after[%h]: got %b expected 0", pats[k], o_busy); end
    end
  endtask

  task automatic test_glitch;
    clear_mon();
    i_rx = 1'b0;
    repeat (4) tick();
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b expected 1", o_busy); end
    tick();
    i_rx = 1'b1;
    repeat (3) tick();
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_by_8: got %b expected 0", o_busy); end
    repeat (2 * CPB) tick();
    n_checks++; if (vld_cycles !== 0) begin n_fail++; $display("FAIL glitch_no_valid: got %0d expected 0", vld_cycles); end
  endtask

  task automatic test_framing;
    i_ready = 1'b1;
    clear_mon();
    send(8'h3C, 1'b0, ^8'h3C);
    n_checks++; if (hs_cnt !== 1) begin n_fail++; $display("FAIL framing_count: got %0d expected 1", hs_cnt); end
    n_checks++; if (hs_data !== 8'h3C) begin n_fail++; $display("FAIL framing_data: got %h expected 3c", hs_data); end
    n_checks++; if (hs_ferr !== 1'b1) begin n_fail++; $display("FAIL framing_flag: got %b expected 1", hs_ferr); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL framing_busy_after: got %b expected 0", o_busy); end
  endtask

  task automatic test_overrun;
    i_ready = 1'b0;
    clear_mon();
    send(8'h11, 1'b1, ^8'h11);
    send(8'h22, 1'b1, ^8'h22);
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid_held: got %b expected 1", o_valid); end
    n_checks++; if (o_data !== 8'h11) begin n_fail++; $display("FAIL overrun_data_held: got %h expected 11", o_data); end
    n_checks++; if (ovr_cnt !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 1", ovr_cnt); end
    i_ready = 1'b1;
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_valid_drop: got %b expected 0", o_valid); end
    n_checks++; if (hs_cnt !== 1 || hs_data !== 8'h11) begin n_fail++; $display("FAIL overrun_consumed: got %0d/%h expected 1/11", hs_cnt, hs_data); end
    repeat (4) tick();
  endtask

  task automatic test_back_to_back;
    i_ready = 1'b0;
    send(8'h44, 1'b1, ^8'h44);
    clear_mon();
    fork
      send(8'h55, 1'b1, ^8'h55);
      begin
        repeat (DONE_TICK - 1) tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
      end
    join
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", o_valid); end
    n_checks++; if (o_data !== 8'h55) begin n_fail++; $display("FAIL b2b_data: got %h expected 55", o_data); end
    n_checks++; if (ovr_cnt !== 0) begin n_fail++; $display("FAIL b2b_overrun: got %0d expected 0", ovr_cnt); end
    n_checks++; if (hs_cnt !== 1 || hs_data !== 8'h44) begin n_fail++; $display("FAIL b2b_first: got %0d/%h expected 1/44", hs_cnt, hs_data); end
    i_ready = 1'b1;
    tick();
    n_checks++; if (hs_data !== 8'h55 || o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %h/%b expected 55/0", hs_data, o_valid); end
  endtask

  task automatic test_reset_mid;
    i_ready = 1'b1;
    clear_mon();
    fork
      send(8'hF7, 1'b1, ^8'hF7);
      begin
        repeat (5 * CPB + 8) tick();
        i_reset = 1'b1;
        tick();
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", o_busy); end
        tick();
        i_reset = 1'b0;
      end
    join
    n_checks++; if (hs_cnt !== 0) begin n_fail++; $display("FAIL midreset_no_frame: got %0d expected 0", hs_cnt); end
    send(8'h5A, 1'b1, ^8'h5A);
    n_checks++; if (hs_cnt !== 1 || hs_data !== 8'h5A) begin n_fail++; $display("FAIL midreset_next: got %0d/%h expected 1/5a", hs_cnt, hs_data); end
    n_checks++; if (hs_ferr !== 1'b0) begin n_fail++; $display("FAIL midreset_next_ferr: got %b expected 0", hs_ferr); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    i_ready = 1'b1;
    clear_mon();
    send(8'h07, 1'b1, 1'b0);
    n_checks++; if (hs_perr !== 1'b1) begin n_fail++; $display("FAIL parity_bad: got %b expected 1", hs_perr); end
    send(8'h07, 1'b1, 1'b1);
    n_checks++; if (hs_perr !== 1'b0) begin n_fail++; $display("FAIL parity_good: got %b expected 0", hs_perr); end
    n_checks++; if (hs_cnt !== 2 || hs_data !== 8'h07) begin n_fail++; $display("FAIL parity_data: got %0d/%h expected 2/07", hs_cnt, hs_data); end
  endtask
`endif

  initial begin
    i_reset = 1'b1;
    i_rx    = 1'b1;
    i_ready = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 22274, clk cycles per UART bit; legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only when UART_RX_PARITY_EN is defined.
REQ-005 clk  input  1  single clock for all logic; all state changes on rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-007 i_rx  input  1  asynchronous serial line, idle high.
REQ-008 o_data  output  DATA_BITS  received word, bit 0 = first data bit on the line (LSB first).
REQ-009 o_valid  output  1  o_data and error flags hold a complete frame.
REQ-010 i_ready  input  1  consumer accepts the frame; handshake occurs when o_valid and i_ready are both 1 on a rising edge.
REQ-011 o_framing_err  output  1  a stop bit of the held frame sampled low; qualified by o_valid.
REQ-012 o_parity_err  output  1  parity mismatch on the held frame; qualified by o_valid; tied 0 without UART_RX_PARITY_EN.
REQ-013 o_overrun  output  1  one-cycle pulse: a completed frame was discarded because the output register was still full.
REQ-014 o_busy  output  1  receiver FSM is not in IDLE.

Function
REQ-015 i_rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (2-cycle input latency).
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP; bit counter width clog2(CLKS_PER_BIT); bit index width clog2(DATA_BITS+1).
REQ-017 IDLE: synchronized low -> START with cycle counter 0; otherwise stay in IDLE.
REQ-018 START: synchronized high before counter reaches CLKS_PER_BIT/2 (integer division) -> IDLE (glitch rejected, no output); counter == CLKS_PER_BIT/2 with line low -> DATA, counter 0, bit index 0.
REQ-019 DATA: counter increments each cycle; at counter == CLKS_PER_BIT-1 sample line into shift position bit index, clear counter, increment index; after bit DATA_BITS-1 -> PARITY if enabled, else STOP.
REQ-020 PARITY: at counter == CLKS_PER_BIT-1 sample parity bit, compute mismatch vs XOR of data bits (inverted if PARITY_ODD), -> STOP.
REQ-021 STOP: sample each stop bit at counter == CLKS_PER_BIT-1; any low sample sets the frame's framing error; after the last stop sample -> IDLE in the same cycle (mid-stop-bit resync).
REQ-022 Frame completion = cycle of the last stop sample; data and both error flags SHALL be loaded into the output register together, o_valid=1 from the next cycle.
REQ-023 Frames with framing or parity error SHALL still be delivered with the flag set.
REQ-024 o_valid and held contents SHALL remain stable until the handshake; o_valid falls the cycle after the handshake.
REQ-025 Completion while o_valid=1 and i_ready=0: new frame discarded, held frame unchanged, o_overrun=1 for exactly one cycle.
REQ-026 Completion in the same cycle as a handshake: new frame loaded, o_valid stays 1, no overrun.
REQ-027 Receiver SHALL accept a new start bit while o_valid=1; output backpressure never stalls the line.

Reset
REQ-028 i_reset=1 SHALL force: FSM IDLE, counters 0, synchronizer flops 1, o_data 0, o_valid 0, o_framing_err 0, o_parity_err 0, o_overrun 0, o_busy 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no output; the next falling edge after reset release starts a fresh frame.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: PARITY state present, one parity bit expected between data and stop bits, o_parity_err driven per REQ-020.
REQ-031 Macro UART_RX_PARITY_EN undefined: PARITY state and logic absent, DATA -> STOP directly, o_parity_err constant 0.

Verification
REQ-032 CLKS_PER_BIT=16, no parity, i_ready=1: send 0xA5 8N1 -> o_valid pulse 1 cycle, o_data=0xA5, both error flags 0.
REQ-033 Low glitch of 5 cycles on idle line -> o_busy returns 0, no o_valid, FSM back in IDLE by cycle 8.
REQ-034 Send 0x3C with stop bit driven low -> o_data=0x3C, o_framing_err=1, o_valid=1.
REQ-035 i_ready=0, send 0x11 then 0x22 -> o_data stays 0x11, one o_overrun pulse at 0x22 completion; raise i_ready -> 0x11 consumed, o_valid=0.
REQ-036 UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity bit 0 -> o_parity_err=1; with parity bit 1 -> o_parity_err=0.
REQ-037 Assert i_reset during data bit 4 of a frame -> no o_valid; following frame 0x5A received correctly.
